lif_neuron: RTL and testbench
=============================

Name: lif_neuron

Overview:
- Leaky integrate-and-fire neuron: the spike source that drives `post_spike` into the stdp synapse block.
- Consumes a presynaptic spike together with the current synaptic weight (from the stdp block's `weight` output).
- Integrates `pre_spike`-gated weight into a leaky membrane potential.
- Emits a one-cycle `post_spike` pulse on threshold crossing, then holds off input for a fixed refractory period.

Parameters:
- WEIGHT_W, 8, width of incoming synaptic weight.
- V_W, 16, membrane potential width (unsigned).
- THRESHOLD, 16'd1024, firing threshold; fire when v_next >= THRESHOLD.
- LEAK_SHIFT, 4, leak per cycle = v >> LEAK_SHIFT. Legal range 1..V_W-1.
- REFRACT_CYCLES, 8, clock edges spent in REFRACT after a fire. 0 = no refractory.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- pre_spike  in  1  presynaptic spike, level-sampled each cycle.
- weight  in  WEIGHT_W  synaptic weight, sampled only in cycles where pre_spike=1.
- post_spike  out  1  registered one-cycle fire pulse.
- membrane  out  V_W  current membrane potential v (registered).
- refractory  out  1  high while state==REFRACT.
- spike_count  out  16  number of fires since reset; saturates at 16'hFFFF.

Behaviour:
- Reset (clk is the clock; reset is synchronous, active-high):
  - v=0, state=INTEGRATE, refr_cnt=0.
  - post_spike=0, refractory=0, spike_count=0.
  - Reset mid-refractory or mid-integration aborts immediately to these values.
- Default: post_spike<=0 every edge unless a fire occurs at that edge (guarantees a single-cycle pulse).
- Arithmetic, computed in V_W+1 bits:
  - v_leak = v - (v >> LEAK_SHIFT).
  - v_sum = v_leak + (pre_spike ? zero-extended weight : 0).
  - v_next = min(v_sum, 2^V_W-1) (saturating, never wraps).
- State INTEGRATE:
  - If v_next >= THRESHOLD: post_spike<=1, v<=0, spike_count<=spike_count+1 (saturating).
    - If REFRACT_CYCLES>0: state<=REFRACT, refr_cnt<=REFRACT_CYCLES.
    - If REFRACT_CYCLES==0: stay in INTEGRATE.
  - Otherwise: v<=v_next.
- State REFRACT:
  - v held at 0; pre_spike and weight ignored, the input is dropped, not queued.
  - If refr_cnt==1: state<=INTEGRATE, refr_cnt<=0. Otherwise refr_cnt<=refr_cnt-1.
  - Exactly REFRACT_CYCLES edges are spent in REFRACT.
- Latency:
  - A crossing evaluated at edge N gives post_spike high during cycle N..N+1.
  - membrane reads 0 in that same cycle.
- Idle decay: v decays geometrically toward 0. v>>LEAK_SHIFT==0 for small v, so v stalls at values below 2^LEAK_SHIFT; this is intended, no rounding.
- weight=0 with pre_spike=1 is leak only.
- A simultaneous fire and spike_count saturation leaves spike_count at FFFF and still pulses post_spike.
- refractory output = (state==REFRACT), registered with state.

Decomposition:
- Package snn_pkg:
  - state enum {INTEGRATE, REFRACT}.
  - Default constants for THRESHOLD, LEAK_SHIFT, REFRACT_CYCLES.
  - Shared WEIGHT_W=8, shared with the stdp block.
- One natural sub-module: lif_refract_timer, a loadable down-counter with a done flag.
- The leak/saturation datapath stays inline.

Test Plan:
1. Single pulse: reset, one cycle pre_spike=1, weight=200, then idle.
   - membrane=200, then 188, then 177, then 166.
   - post_spike stays 0.
2. Constant drive at weight=128, pre_spike held high:
   - membrane reads 128, 248, 361, 467, 566, 659, 746, 828, 905, 977.
   - The 11th edge fires: post_spike=1 for exactly one cycle, membrane=0, refractory=1, spike_count=1.
3. Refractory and period check at weight=255, pre_spike held high:
   - membrane reads 255, 495, 720, 930.
   - Fire occurs at edge 5, then refractory=1 for 8 cycles.
   - Further fires at edges 18 and 31 (period 13 cycles).
   - membrane stays 0 throughout REFRACT.
4. Reset mid-refractory: assert reset 3 cycles after a fire.
   - Next cycle: refractory=0, membrane=0, spike_count=0, state INTEGRATE.
   - The next pre_spike (weight=100) gives membrane=100.
5. REFRACT_CYCLES=0 variant with weight=255 constant:
   - Fires every 5 cycles, refractory never asserted.
6. Saturation variant: THRESHOLD=16'hFFFF, V_W=16, force v near the max with weight=255 held.
   - membrane clamps at 16'hFFFF and never wraps.
   - Fire occurs when v_next==FFFF.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types and default constants for the spiking-network blocks
// (LIF neuron and STDP synapse).
package snn_pkg;

  localparam int          WEIGHT_W               = 8;
  localparam int          V_W_DEFAULT            = 16;
  localparam logic [15:0] THRESHOLD_DEFAULT      = 16'd1024;
  localparam int          LEAK_SHIFT_DEFAULT     = 4;
  localparam int          REFRACT_CYCLES_DEFAULT = 8;

  typedef enum logic [0:0] {
    INTEGRATE = 1'b0,
    REFRACT   = 1'b1
  } state_t;

  // Width of a counter that has to hold values 0..n. It is never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/lif_neuron_if.sv
// Spike/weight input and membrane/fire status bundle of one LIF neuron.
interface lif_neuron_if
  import snn_pkg::*;
#(
  parameter int WEIGHT_W = snn_pkg::WEIGHT_W,
  parameter int V_W      = V_W_DEFAULT
);
  logic                pre_spike;
  logic [WEIGHT_W-1:0] weight;
  logic                post_spike;
  logic [V_W-1:0]      membrane;
  logic                refractory;
  logic [15:0]         spike_count;

  modport master (
    output pre_spike, weight,
    input  post_spike, membrane, refractory, spike_count
  );

  modport slave (
    input  pre_spike, weight,
    output post_spike, membrane, refractory, spike_count
  );
endinterface

// File: rtl/lif_refract_timer.sv
// Loadable down-counter for the refractory hold-off. Done marks the final
// refractory edge, which is the point where the count equals 1.
module lif_refract_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             done
);
  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - CNT_W'(1);
    end
  end

  assign done = (count_reg == CNT_W'(1));
endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron. It integrates weight gated by pre_spike into a
// saturating membrane. It fires a one-cycle pulse, then ignores input for a fixed refractory period.
module lif_neuron
  import snn_pkg::*;
#(
  parameter int             WEIGHT_W       = snn_pkg::WEIGHT_W,
  parameter int             V_W            = V_W_DEFAULT,
  parameter logic [V_W-1:0] THRESHOLD      = V_W'(THRESHOLD_DEFAULT),
  parameter int             LEAK_SHIFT     = LEAK_SHIFT_DEFAULT,
  parameter int             REFRACT_CYCLES = REFRACT_CYCLES_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  lif_neuron_if.slave  bus
);
  localparam int   CNT_W       = cnt_width(REFRACT_CYCLES);
  localparam logic HAS_REFRACT = (REFRACT_CYCLES > 0);

  state_t         state_reg;
  logic [V_W-1:0] v_reg;
  logic           post_reg;
  logic [15:0]    count_reg;

  logic [V_W:0]   v_leak;
  logic [V_W:0]   v_sum;
  logic [V_W-1:0] v_next;
  logic           fire;
  logic           timer_done;

  // The extra top bit of v_sum catches overflow, and the result is clamped at the ceiling instead of wrapping.
  always_comb begin
    v_leak = {1'b0, v_reg} - ({1'b0, v_reg} >> LEAK_SHIFT);
    v_sum  = v_leak + (bus.pre_spike ? {{(V_W + 1 - WEIGHT_W){1'b0}}, bus.weight}
                                     : {(V_W + 1){1'b0}});
    v_next = v_sum[V_W] ? {V_W{1'b1}} : v_sum[V_W-1:0];
    fire   = (state_reg == INTEGRATE) && (v_next >= THRESHOLD);
  end

  lif_refract_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (fire && HAS_REFRACT),
    .load_value (CNT_W'(REFRACT_CYCLES)),
    .done       (timer_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= INTEGRATE;
      v_reg     <= '0;
      post_reg  <= 1'b0;
      count_reg <= '0;
    end else begin
      post_reg <= 1'b0;
      case (state_reg)
        INTEGRATE: begin
          if (fire) begin
            post_reg <= 1'b1;
            v_reg    <= '0;
            if (count_reg != 16'hFFFF) count_reg <= count_reg + 16'd1;
            if (HAS_REFRACT) state_reg <= REFRACT;
          end else begin
            v_reg <= v_next;
          end
        end
        REFRACT: begin
          v_reg <= '0;
          if (timer_done) state_reg <= INTEGRATE;
        end
        default: state_reg <= INTEGRATE;
      endcase
    end
  end

  assign bus.post_spike  = post_reg;
  assign bus.membrane    = v_reg;
  assign bus.refractory  = (state_reg == REFRACT);
  assign bus.spike_count = count_reg;
endmodule

// File: tb/tb_lif_neuron.sv
// Bench for lif_neuron. It uses three parameterisations: the default one, one with no refractory
// period, and one at the saturation ceiling. Expected values come from tables and a reference model.
module tb_lif_neuron;
  import snn_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       pre [3];
  logic [7:0] wt  [3];

  logic        obs_post [3];
  logic [15:0] obs_mem  [3];
  logic        obs_refr [3];
  logic [15:0] obs_cnt  [3];

  lif_neuron_if #(.WEIGHT_W(8), .V_W(16)) ifa ();
  lif_neuron_if #(.WEIGHT_W(8), .V_W(16)) ifb ();
  lif_neuron_if #(.WEIGHT_W(8), .V_W(16)) ifc ();

  assign ifa.pre_spike = pre[0];
  assign ifa.weight    = wt[0];
  assign ifb.pre_spike = pre[1];
  assign ifb.weight    = wt[1];
  assign ifc.pre_spike = pre[2];
  assign ifc.weight    = wt[2];

  assign obs_post[0] = ifa.post_spike;
  assign obs_mem[0]  = ifa.membrane;
  assign obs_refr[0] = ifa.refractory;
  assign obs_cnt[0]  = ifa.spike_count;
  assign obs_post[1] = ifb.post_spike;
  assign obs_mem[1]  = ifb.membrane;
  assign obs_refr[1] = ifb.refractory;
  assign obs_cnt[1]  = ifb.spike_count;
  assign obs_post[2] = ifc.post_spike;
  assign obs_mem[2]  = ifc.membrane;
  assign obs_refr[2] = ifc.refractory;
  assign obs_cnt[2]  = ifc.spike_count;

  lif_neuron #(.V_W(16)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  lif_neuron #(.V_W(16), .REFRACT_CYCLES(0)) dut_b (.clk(clk), .reset(reset), .bus(ifb));
  lif_neuron #(.V_W(16), .THRESHOLD(16'hFFFF), .LEAK_SHIFT(15)) dut_c (.clk(clk), .reset(reset), .bus(ifc));

  typedef struct {
    logic        pre;
    logic [7:0]  w;
    logic        post;
    logic [15:0] mem;
    logic        refr;
    logic [15:0] cnt;
  } vec_t;

  typedef struct {
    string       tag;
    logic        post;
    logic [15:0] mem;
    logic        refr;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int m_v [3];
  int m_st[3];
  int m_rc[3];
  int m_cnt[3];

  function automatic int p_thr(input int d);
    return (d == 2) ? 65535 : 1024;
  endfunction
  function automatic int p_ls(input int d);
    return (d == 2) ? 15 : 4;
  endfunction
  function automatic int p_rc(input int d);
    return (d == 1) ? 0 : 8;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_v[d] = 0; m_st[d] = 0; m_rc[d] = 0; m_cnt[d] = 0;
    end
  endtask

  // Reference behaviour, computed directly from the neuron's definition.
  task automatic model_step(input int d, input logic p, input logic [7:0] w,
                            input string tag, output exp_t e);
    int vl, s, vn;
    e.tag  = tag;
    e.post = 1'b0;
    if (m_st[d] != 0) begin
      m_v[d] = 0;
      if (m_rc[d] == 1) begin m_st[d] = 0; m_rc[d] = 0; end
      else m_rc[d] = m_rc[d] - 1;
    end else begin
      vl = m_v[d] - (m_v[d] >> p_ls(d));
      s  = vl + (p ? int'(w) : 0);
      vn = (s > 65535) ? 65535 : s;
      if (vn >= p_thr(d)) begin
        e.post = 1'b1;
        m_v[d] = 0;
        if (m_cnt[d] != 65535) m_cnt[d] = m_cnt[d] + 1;
        if (p_rc(d) > 0) begin m_st[d] = 1; m_rc[d] = p_rc(d); end
      end else begin
        m_v[d] = vn;
      end
    end
    e.mem  = 16'(m_v[d]);
    e.refr = (m_st[d] != 0);
    e.cnt  = 16'(m_cnt[d]);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin pre[d] = 1'b0; wt[d] = 8'd0; end
    @(posedge clk);
    #1;
    model_reset();
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s_post%0d", tag, d), int'(obs_post[d]), 0);
      check($sformatf("%s_mem%0d",  tag, d), int'(obs_mem[d]),  0);
      check($sformatf("%s_refr%0d", tag, d), int'(obs_refr[d]), 0);
      check($sformatf("%s_cnt%0d",  tag, d), int'(obs_cnt[d]),  0);
    end
    $display("reset %s: all neurons cleared", tag);
  endtask

  // One transaction: drive the inputs, queue the expected result, and compare after the edge.
  task automatic step(input int d, input logic p, input logic [7:0] w, input exp_t e);
    exp_t x;
    @(negedge clk);
    reset = 1'b0;
    pre[d] = p;
    wt[d]  = w;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check({x.tag, "_post"}, int'(obs_post[d]), int'(x.post));
    check({x.tag, "_mem"},  int'(obs_mem[d]),  int'(x.mem));
    check({x.tag, "_refr"}, int'(obs_refr[d]), int'(x.refr));
    check({x.tag, "_cnt"},  int'(obs_cnt[d]),  int'(x.cnt));
    $display("%s dut%0d pre=%0b w=%0d -> post=%0b mem=%0d refr=%0b cnt=%0d",
             x.tag, d, p, w, obs_post[d], obs_mem[d], obs_refr[d], obs_cnt[d]);
  endtask

  task automatic run_table(input string tag, input vec_t vt[$]);
    exp_t e;
    foreach (vt[i]) begin
      e.tag  = $sformatf("%s_%0d", tag, i + 1);
      e.post = vt[i].post;
      e.mem  = vt[i].mem;
      e.refr = vt[i].refr;
      e.cnt  = vt[i].cnt;
      step(0, vt[i].pre, vt[i].w, e);
    end
  endtask

  initial begin
    vec_t t1[$];
    vec_t t2[$];
    exp_t e;
    int   fires[$];
    int   refr_total;
    int   fire_edge;
    int   last_mem;
    int   wraps;
    int   mem_before;
    int   t2_mems[10] = '{128, 248, 361, 467, 566, 659, 746, 828, 905, 977};

    t1.push_back('{1'b1, 8'd200, 1'b0, 16'd200, 1'b0, 16'd0});
    t1.push_back('{1'b0, 8'd0,   1'b0, 16'd188, 1'b0, 16'd0});
    t1.push_back('{1'b0, 8'd0,   1'b0, 16'd177, 1'b0, 16'd0});
    t1.push_back('{1'b0, 8'd0,   1'b0, 16'd166, 1'b0, 16'd0});
    for (int i = 0; i < 10; i++)
      t2.push_back('{1'b1, 8'd128, 1'b0, 16'(t2_mems[i]), 1'b0, 16'd0});
    t2.push_back('{1'b1, 8'd128, 1'b1, 16'd0, 1'b1, 16'd1});
    t2.push_back('{1'b1, 8'd128, 1'b0, 16'd0, 1'b1, 16'd1});

    for (int d = 0; d < 3; d++) begin pre[d] = 1'b0; wt[d] = 8'd0; end

    // Test 1: a single pulse, followed by leak-only decay
    do_reset("rst1");
    run_table("t1", t1);

    // Test 2: constant drive at weight 128. The 11th edge fires, and the pulse lasts one cycle.
    do_reset("rst2");
    run_table("t2", t2);

    // Test 3: refractory length and firing period at weight 255
    do_reset("rst3");
    refr_total = 0;
    for (int k = 1; k <= 31; k++) begin
      model_step(0, 1'b1, 8'd255, $sformatf("t3_e%0d", k), e);
      step(0, 1'b1, 8'd255, e);
      if (obs_post[0]) fires.push_back(k);
      if (obs_refr[0]) refr_total++;
    end
    check("t3_fire_count", fires.size(), 3);
    for (int i = 0; i < fires.size() && i < 3; i++)
      check($sformatf("t3_fire_edge%0d", i), fires[i], 5 + 13 * i);
    check("t3_refr_cycles", refr_total, 17);

    // Test 4: a reset asserted three cycles after a fire, while the neuron is refractory
    do_reset("rst4a");
    for (int k = 1; k <= 7; k++) begin
      model_step(0, 1'b1, 8'd255, $sformatf("t4_e%0d", k), e);
      step(0, 1'b1, 8'd255, e);
    end
    do_reset("t4_midrefr");
    e = '{"t4_after", 1'b0, 16'd100, 1'b0, 16'd0};
    step(0, 1'b1, 8'd100, e);

    // Test 5: no refractory period, so the neuron fires every 5 cycles
    do_reset("rst5");
    fires.delete();
    refr_total = 0;
    for (int k = 1; k <= 20; k++) begin
      model_step(1, 1'b1, 8'd255, $sformatf("t5_e%0d", k), e);
      step(1, 1'b1, 8'd255, e);
      if (obs_post[1]) fires.push_back(k);
      if (obs_refr[1]) refr_total++;
    end
    check("t5_fire_count", fires.size(), 4);
    for (int i = 0; i < fires.size() && i < 4; i++)
      check($sformatf("t5_fire_edge%0d", i), fires[i], 5 * (i + 1));
    check("t5_refr_cycles", refr_total, 0);

    // Test 6: the membrane climbs to the ceiling. It must clamp rather than wrap, and fire at v_next == FFFF.
    do_reset("rst6");
    fire_edge  = -1;
    last_mem   = 0;
    wraps      = 0;
    mem_before = -1;
    for (int k = 1; k <= 400 && fire_edge < 0; k++) begin
      model_step(2, 1'b1, 8'd255, $sformatf("t6_e%0d", k), e);
      step(2, 1'b1, 8'd255, e);
      if (obs_post[2]) begin
        fire_edge  = k;
        mem_before = last_mem;
      end else begin
        if (int'(obs_mem[2]) < last_mem) wraps++;
        last_mem = int'(obs_mem[2]);
      end
    end
    check("t6_fire_edge", fire_edge, 258);
    check("t6_mem_before_fire", mem_before, 65407);
    check("t6_no_wrap", wraps, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
